vram_bus_arbiter: RTL and testbench
===================================

// Module: vram_bus_arbiter
// PURPOSE
//  Sequences the 8 KiB video RAM bus (MA[12:0], MD[7:0], nMCS/nMOE/nMWR) and shares it between the PPU fetcher, OAM DMA source reads and CPU accesses.
//  Sits between the PPU/DMA/CPU-bus blocks and the VRAM pin interface. Issues one non-preemptive access at a time with fixed pin timing.
//  Applies DMG lockout rules: during PPU lock, CPU reads return 0xFF and CPU writes are dropped.
// PARAMETERS
//  ACC_CYC    2   clk1 cycles per VRAM access (legal range 2..8)
//  AW         13  VRAM address width
// PORTS
//  clk1        in   1   system clock; all state changes on its rising edge
//  nreset      in   1   asynchronous, active-low reset
//  ppu_req     in   1   PPU fetch request (level, held until ppu_done)
//  ppu_addr    in   AW  PPU fetch address
//  ppu_lock    in   1   PPU in pixel-transfer mode; CPU denied VRAM
//  dma_req     in   1   DMA source read from VRAM (level)
//  dma_addr    in   AW  DMA source address
//  cpu_req     in   1   CPU VRAM access request (level)
//  cpu_wr      in   1   1 = write, 0 = read; valid while cpu_req is high
//  cpu_addr    in   AW  CPU address (A[12:0])
//  cpu_wdata   in   8   CPU write data
//  md_in       in   8   VRAM data-bus input
//  ma          out  AW  VRAM address-bus output
//  md_out      out  8   VRAM data-bus output
//  md_drv      out  1   drive enable for md_out
//  mcs_n       out  1   chip select, active low
//  moe_n       out  1   output enable, active low
//  mwr_n       out  1   write strobe, active low
//  ppu_done    out  1   1-cycle pulse; rdata is valid
//  dma_done    out  1   1-cycle pulse; rdata is valid
//  cpu_done    out  1   1-cycle pulse; rdata is valid for a read
//  cpu_denied  out  1   1-cycle pulse together with cpu_done when the access was locked out
//  rdata       out  8   data returned for the last completed read
// BEHAVIOUR
//  - Reset values: ma=0, md_out=0, md_drv=0, mcs_n=moe_n=mwr_n=1, all done/denied pulses 0, rdata=0xFF, state=IDLE, cnt=0.
//  - Reset is asynchronous and aborts any in-flight access at once. All strobes go inactive within the reset, with no partial write completion.
//  - States: IDLE, BUSY.
//  - Arbitration point: any edge in IDLE, or the edge ending the last BUSY cycle (cnt==ACC_CYC-1). This allows back-to-back accesses with no dead cycle.
//  - Priority: ppu > dma > cpu. The winner's address, wr flag and owner are latched; the latched values do not change mid-access.
//  - cpu_req with ppu_lock=1 at the arbitration point, and no PPU/DMA winner: no bus cycle is run. The next cycle has cpu_done=1, cpu_denied=1 and rdata=0xFF (for a read); writes are discarded. The arbiter stays in IDLE.
//  - BUSY cycle k (k = 0..ACC_CYC-1):
//      - mcs_n=0 for all k, and ma = latched address.
//      - Read: moe_n=0 for all k.
//      - Write: md_drv=1 and md_out=cpu_wdata for all k; mwr_n=0 only for k>=1.
//  - Last BUSY cycle: md_in is captured into rdata (reads). The owner's done pulse is high in the following cycle, and that cycle is the next arbitration/BUSY k=0.
//  - Latency: a request accepted at edge E produces done high in cycle E+ACC_CYC.
//  - Requests are levels. A req still high on the edge where done rises counts as a new request, so requesters drop req on seeing done.
//  - ppu_lock rising during a CPU access does not preempt it; the access completes normally.
//  - With no requests: IDLE, pins inactive, ma holds its last value.
// CONFIGURATION
//  - VRAM_ARB_RR_EN defined: dma and cpu share the second priority level round-robin. The last-served of the two loses a tie. ppu keeps absolute priority.
//  - VRAM_ARB_RR_EN undefined: fixed order ppu > dma > cpu.
// STRUCTURE
//  - Package dmg_vram_pkg:
//      - owner_t enum {OWN_NONE, OWN_PPU, OWN_DMA, OWN_CPU}
//      - VRAM_AW=13
//      - VRAM_LOCK_DATA=8'hFF
//  - Sub-module vram_arb_pick: combinational winner select from reqs, ppu_lock and the RR pointer. Outputs owner_t and a deny flag.
//  - Top: state/cnt registers, address/data latches and strobe decode.
// TESTING
//  1. Reset sequence: nreset low mid-write (k=1) -> mwr_n=1, mcs_n=1 and md_drv=0 immediately, rdata=0xFF; after release the arbiter is in IDLE.
//  2. CPU write: cpu_req=1, wr=1, addr=0x1800, wdata=0x5A, ACC_CYC=2 -> mcs_n low 2 cycles, mwr_n low in cycle 2 only, cpu_done at E+2, model VRAM[0x1800]=0x5A.
//  3. Simultaneous ppu/dma/cpu reads -> served in order ppu, dma, cpu back-to-back with no idle cycle; each done pulse is followed by the correct rdata.
//  4. Lockout: ppu_lock=1, cpu read 0x0000 -> cpu_done with cpu_denied=1 one cycle later, rdata=0xFF, mcs_n stays 1. A locked write leaves VRAM unchanged.
//  5. ppu_lock rises at BUSY k=0 of a CPU write -> the write completes and VRAM is updated.
//  6. VRAM_ARB_RR_EN with dma_req and cpu_req held high -> grants alternate dma, cpu, dma, cpu. Without the macro -> dma only until it drops req.

Source files
------------

// File: rtl/dmg_vram_pkg.sv
// Shared types and constants for the DMG VRAM bus arbiter.
package dmg_vram_pkg;

    localparam int unsigned VRAM_AW        = 13;
    localparam logic [7:0]  VRAM_LOCK_DATA = 8'hFF;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_PPU,
        OWN_DMA,
        OWN_CPU
    } owner_t;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

    // Per-access attributes latched at the arbitration point
    typedef struct packed {
        owner_t owner;
        logic   wr;
    } acc_t;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational VRAM winner select: ppu > dma > cpu, with a locked-out CPU flagged as denied.
// Build option VRAM_ARB_RR_EN: dma and cpu share the second level round-robin.
module vram_arb_pick
    import dmg_vram_pkg::*;
(
    input  logic   ppu_req,
    input  logic   dma_req,
    input  logic   cpu_req,
    input  logic   ppu_lock,
    input  logic   rr_cpu_last,
    output owner_t win_c,
    output logic   deny_c
);

    logic cpu_ok;

    assign cpu_ok = cpu_req && !ppu_lock;

`ifndef VRAM_ARB_RR_EN
    logic unused_rr;
    assign unused_rr = rr_cpu_last;
`endif

    // A locked CPU never competes with DMA; it is only denied when nothing else wants the bus
    always_comb begin
        win_c  = OWN_NONE;
        deny_c = 1'b0;
        if (ppu_req) begin
            win_c = OWN_PPU;
        end else if (dma_req && cpu_ok) begin
`ifdef VRAM_ARB_RR_EN
            win_c = rr_cpu_last ? OWN_DMA : OWN_CPU;
`else
            win_c = OWN_DMA;
`endif
        end else if (dma_req) begin
            win_c = OWN_DMA;
        end else if (cpu_ok) begin
            win_c = OWN_CPU;
        end else if (cpu_req) begin
            deny_c = 1'b1;
        end
    end

endmodule

// File: rtl/vram_bus_arbiter.sv
// VRAM bus sequencer shared by PPU fetch, OAM DMA reads and CPU accesses, with DMG lockout.
// Build option VRAM_ARB_RR_EN selects round-robin between dma and cpu (see vram_arb_pick).
module vram_bus_arbiter
    import dmg_vram_pkg::*;
#(
    parameter int unsigned ACC_CYC = 2,
    parameter int unsigned AW      = VRAM_AW
) (
    input  logic          clk1,
    input  logic          nreset,
    input  logic          ppu_req,
    input  logic [AW-1:0] ppu_addr,
    input  logic          ppu_lock,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic [7:0]    md_in,
    output logic [AW-1:0] ma,
    output logic [7:0]    md_out,
    output logic          md_drv,
    output logic          mcs_n,
    output logic          moe_n,
    output logic          mwr_n,
    output logic          ppu_done,
    output logic          dma_done,
    output logic          cpu_done,
    output logic          cpu_denied,
    output logic [7:0]    rdata
);

    localparam int unsigned   CW       = 3;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    acc_t          acc_q, acc_d;
    logic          rr_q, rr_d;

    logic [AW-1:0] ma_d;
    logic [7:0]    md_out_d, rdata_d;
    logic          md_drv_d, mcs_n_d, moe_n_d, mwr_n_d;
    logic          ppu_done_d, dma_done_d, cpu_done_d, cpu_denied_d;

    owner_t        win_c;
    logic          deny_c;
    logic          last_c, arb_c, win_wr_c;

    vram_arb_pick u_pick (
        .ppu_req     (ppu_req),
        .dma_req     (dma_req),
        .cpu_req     (cpu_req),
        .ppu_lock    (ppu_lock),
        .rr_cpu_last (rr_q),
        .win_c       (win_c),
        .deny_c      (deny_c)
    );

    assign last_c   = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
    assign arb_c    = (state_q == ST_IDLE) || last_c;
    assign win_wr_c = (win_c == OWN_CPU) && cpu_wr;

    // Next-state, strobe decode and completion; all results are registered below
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        rr_d         = rr_q;
        ma_d         = ma;
        md_out_d     = md_out;
        md_drv_d     = md_drv;
        mcs_n_d      = mcs_n;
        moe_n_d      = moe_n;
        mwr_n_d      = mwr_n;
        rdata_d      = rdata;
        ppu_done_d   = 1'b0;
        dma_done_d   = 1'b0;
        cpu_done_d   = 1'b0;
        cpu_denied_d = 1'b0;

        if (state_q == ST_BUSY) begin
            if (!last_c) begin
                cnt_d   = cnt_q + CW'(1);
                mwr_n_d = !acc_q.wr;
            end else begin
                if (!acc_q.wr) begin
                    rdata_d = md_in;
                end
                ppu_done_d = (acc_q.owner == OWN_PPU);
                dma_done_d = (acc_q.owner == OWN_DMA);
                cpu_done_d = (acc_q.owner == OWN_CPU);
            end
        end

        if (arb_c) begin
            if (win_c != OWN_NONE) begin
                state_d     = ST_BUSY;
                cnt_d       = '0;
                acc_d.owner = win_c;
                acc_d.wr    = win_wr_c;
                mcs_n_d     = 1'b0;
                moe_n_d     = win_wr_c;
                mwr_n_d     = 1'b1;
                md_drv_d    = win_wr_c;
                if (win_wr_c) begin
                    md_out_d = cpu_wdata;
                end
                case (win_c)
                    OWN_PPU: ma_d = ppu_addr;
                    OWN_DMA: ma_d = dma_addr;
                    default: ma_d = cpu_addr;
                endcase
                if (win_c != OWN_PPU) begin
                    rr_d = (win_c == OWN_CPU);
                end
            end else begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                acc_d    = '{owner: OWN_NONE, wr: 1'b0};
                mcs_n_d  = 1'b1;
                moe_n_d  = 1'b1;
                mwr_n_d  = 1'b1;
                md_drv_d = 1'b0;
                // Denial is only issued from IDLE so it never shares a cycle with a completion
                if (deny_c && (state_q == ST_IDLE)) begin
                    cpu_done_d   = 1'b1;
                    cpu_denied_d = 1'b1;
                    rr_d         = 1'b1;
                    if (!cpu_wr) begin
                        rdata_d = VRAM_LOCK_DATA;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '{owner: OWN_NONE, wr: 1'b0};
            rr_q       <= 1'b1;
            ma         <= '0;
            md_out     <= '0;
            md_drv     <= 1'b0;
            mcs_n      <= 1'b1;
            moe_n      <= 1'b1;
            mwr_n      <= 1'b1;
            rdata      <= VRAM_LOCK_DATA;
            ppu_done   <= 1'b0;
            dma_done   <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_denied <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rr_q       <= rr_d;
            ma         <= ma_d;
            md_out     <= md_out_d;
            md_drv     <= md_drv_d;
            mcs_n      <= mcs_n_d;
            moe_n      <= moe_n_d;
            mwr_n      <= mwr_n_d;
            rdata      <= rdata_d;
            ppu_done   <= ppu_done_d;
            dma_done   <= dma_done_d;
            cpu_done   <= cpu_done_d;
            cpu_denied <= cpu_denied_d;
        end
    end

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Self-checking bench for vram_bus_arbiter: transaction-level reference model, pin-level VRAM,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram_bus_arbiter;

    localparam int unsigned ACC = 2;
    localparam int unsigned AW  = 13;

    logic          clk1 = 1'b0;
    logic          nreset = 1'b0;
    logic          ppu_req = 1'b0, dma_req = 1'b0, cpu_req = 1'b0, ppu_lock = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] ppu_addr = '0, dma_addr = '0, cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic [7:0]    md_in;
    logic [AW-1:0] ma;
    logic [7:0]    md_out, rdata;
    logic          md_drv, mcs_n, moe_n, mwr_n, ppu_done, dma_done, cpu_done, cpu_denied;

    int checks = 0;
    int errors = 0;

    always #5 clk1 = ~clk1;

    vram_bus_arbiter #(.ACC_CYC(ACC), .AW(AW)) dut (
        .clk1(clk1), .nreset(nreset),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_lock(ppu_lock),
        .dma_req(dma_req), .dma_addr(dma_addr),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .md_in(md_in), .ma(ma), .md_out(md_out), .md_drv(md_drv),
        .mcs_n(mcs_n), .moe_n(moe_n), .mwr_n(mwr_n),
        .ppu_done(ppu_done), .dma_done(dma_done), .cpu_done(cpu_done),
        .cpu_denied(cpu_denied), .rdata(rdata)
    );

    // Pin-level VRAM device: initial contents are low address byte XOR 0xC3
    logic [7:0] ram [0:8191];
    bit ram_ready = 1'b0;
    assign md_in = (!mcs_n && !moe_n) ? ram[ma] : 8'hA5;

    always @(posedge clk1) begin
        if (!ram_ready) begin
            for (int i = 0; i < 8192; i++) ram[i] = 8'(i) ^ 8'hC3;
            ram_ready = 1'b1;
        end else if (nreset && !mcs_n && !mwr_n) begin
            ram[ma] = md_out;
        end
    end

    // Reference model: owner 0 none, 1 ppu, 2 dma, 3 cpu; m_k is the cycle index within an access
    logic [7:0]    ref_mem [0:8191];
    bit            mem_ready = 1'b0;
    int            m_own, m_k, m_rr_last;
    logic [AW-1:0] m_addr;
    logic          m_wr;
    logic [7:0]    m_wdata;
    logic [AW-1:0] e_ma;
    logic [7:0]    e_md_out, e_rdata;
    logic          e_md_drv, e_mcs_n, e_moe_n, e_mwr_n;
    logic          e_ppu_done, e_dma_done, e_cpu_done, e_cpu_denied;

    function automatic int pick_owner();
        bit cpu_ok;
        cpu_ok = cpu_req && !ppu_lock;
        if (ppu_req) return 1;
        if (dma_req && cpu_ok) begin
`ifdef VRAM_ARB_RR_EN
            return (m_rr_last == 2) ? 3 : 2;
`else
            return 2;
`endif
        end
        if (dma_req) return 2;
        if (cpu_ok) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i) ^ 8'hC3;
            mem_ready = 1'b1;
        end
        m_own = 0; m_k = 0; m_rr_last = 3; m_addr = '0; m_wr = 1'b0; m_wdata = '0;
        e_ma = '0; e_md_out = '0; e_rdata = 8'hFF; e_md_drv = 1'b0;
        e_mcs_n = 1'b1; e_moe_n = 1'b1; e_mwr_n = 1'b1;
        e_ppu_done = 1'b0; e_dma_done = 1'b0; e_cpu_done = 1'b0; e_cpu_denied = 1'b0;
    endtask

    task automatic model_step();
        bit was_idle, fin;
        int w;
        was_idle = (m_own == 0);
        fin = !was_idle && (m_k == int'(ACC) - 1);
        e_ppu_done = 1'b0; e_dma_done = 1'b0; e_cpu_done = 1'b0; e_cpu_denied = 1'b0;
        if (!was_idle && !fin) m_k++;
        if (fin) begin
            e_ppu_done = (m_own == 1);
            e_dma_done = (m_own == 2);
            e_cpu_done = (m_own == 3);
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else      e_rdata = ref_mem[m_addr];
            m_own = 0;
        end
        if (m_own == 0) begin
            w = pick_owner();
            if (w != 0) begin
                m_own   = w;
                m_k     = 0;
                m_wr    = (w == 3) && cpu_wr;
                m_wdata = cpu_wdata;
                m_addr  = (w == 1) ? ppu_addr : (w == 2) ? dma_addr : cpu_addr;
                if (w != 1) m_rr_last = w;
                e_ma = m_addr;
                if (m_wr) e_md_out = m_wdata;
            end else if (was_idle && cpu_req && ppu_lock) begin
                e_cpu_done   = 1'b1;
                e_cpu_denied = 1'b1;
                m_rr_last    = 3;
                if (!cpu_wr) e_rdata = 8'hFF;
            end
        end
        e_mcs_n  = (m_own == 0);
        e_moe_n  = !(m_own != 0 && !m_wr);
        e_md_drv = (m_own != 0) && m_wr;
        e_mwr_n  = !((m_own != 0) && m_wr && (m_k >= 1));
    endtask

    always @(posedge clk1 or negedge nreset) begin
        if (!nreset) model_reset();
        else         model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("ma", 32'(ma), 32'(e_ma));
        check("mcs_n", 32'(mcs_n), 32'(e_mcs_n));
        check("moe_n", 32'(moe_n), 32'(e_moe_n));
        check("mwr_n", 32'(mwr_n), 32'(e_mwr_n));
        check("md_drv", 32'(md_drv), 32'(e_md_drv));
        if (e_md_drv) check("md_out", 32'(md_out), 32'(e_md_out));
        check("ppu_done", 32'(ppu_done), 32'(e_ppu_done));
        check("dma_done", 32'(dma_done), 32'(e_dma_done));
        check("cpu_done", 32'(cpu_done), 32'(e_cpu_done));
        check("cpu_denied", 32'(cpu_denied), 32'(e_cpu_denied));
        check("rdata", 32'(rdata), 32'(e_rdata));
    endtask

    task automatic tick();
        @(negedge clk1);
        if (nreset) compare_model();
    endtask

    int grants [4];
    int exp_grants [4];
    int n_grants;
    int diffs;

    initial begin
`ifdef VRAM_ARB_RR_EN
        exp_grants = '{2, 3, 2, 3};
`else
        exp_grants = '{2, 2, 2, 2};
`endif
        repeat (3) @(negedge clk1);
        nreset = 1'b1;
        tick();
        check("rst_rdata", 32'(rdata), 32'h0FF);
        check("rst_ma", 32'(ma), 32'h0);
        check("rst_mcs_n", 32'(mcs_n), 32'h1);
        check("rst_mwr_n", 32'(mwr_n), 32'h1);
        check("rst_md_drv", 32'(md_drv), 32'h0);

        // Reset in the middle of a write
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h0500; cpu_wdata = 8'h99;
        tick();
        check("t1_k0_mcs_n", 32'(mcs_n), 32'h0);
        tick();
        check("t1_k1_mwr_n", 32'(mwr_n), 32'h0);
        #2 nreset = 1'b0; cpu_req = 1'b0;
        #1;
        check("t1_rst_mwr_n", 32'(mwr_n), 32'h1);
        check("t1_rst_mcs_n", 32'(mcs_n), 32'h1);
        check("t1_rst_md_drv", 32'(md_drv), 32'h0);
        check("t1_rst_rdata", 32'(rdata), 32'h0FF);
        tick();
        nreset = 1'b1;
        tick();
        check("t1_idle_mcs_n", 32'(mcs_n), 32'h1);
        check("t1_no_write", 32'(ram[13'h0500]), 32'h0C3);

        // CPU write
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h1800; cpu_wdata = 8'h5A;
        tick();
        check("t2_k0_mcs_n", 32'(mcs_n), 32'h0);
        check("t2_k0_mwr_n", 32'(mwr_n), 32'h1);
        check("t2_k0_md_out", 32'(md_out), 32'h5A);
        repeat (ACC - 1) tick();
        check("t2_k1_mwr_n", 32'(mwr_n), 32'h0);
        cpu_req = 1'b0;
        tick();
        check("t2_cpu_done", 32'(cpu_done), 32'h1);
        check("t2_mem", 32'(ram[13'h1800]), 32'h5A);
        tick();

        // Simultaneous reads, each requester drops req in its last access cycle
        ppu_addr = 13'h0111; dma_addr = 13'h0222; cpu_addr = 13'h0333; cpu_wr = 1'b0;
        ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1;
        repeat (ACC) tick();
        ppu_req = 1'b0;
        tick();
        check("t3_ppu_done", 32'(ppu_done), 32'h1);
        check("t3_ppu_rdata", 32'(rdata), 32'h0D2);
        check("t3_dma_started", 32'(mcs_n), 32'h0);
        repeat (ACC - 1) tick();
        dma_req = 1'b0;
        tick();
        check("t3_dma_done", 32'(dma_done), 32'h1);
        check("t3_dma_rdata", 32'(rdata), 32'h0E1);
        check("t3_cpu_started", 32'(mcs_n), 32'h0);
        repeat (ACC - 1) tick();
        cpu_req = 1'b0;
        tick();
        check("t3_cpu_done", 32'(cpu_done), 32'h1);
        check("t3_cpu_rdata", 32'(rdata), 32'h0F0);
        tick();

        // Lockout: read returns 0xFF, write is dropped
        ppu_lock = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0000;
        tick();
        check("t4_rd_done", 32'(cpu_done), 32'h1);
        check("t4_rd_denied", 32'(cpu_denied), 32'h1);
        check("t4_rd_rdata", 32'(rdata), 32'h0FF);
        check("t4_rd_mcs_n", 32'(mcs_n), 32'h1);
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h0040; cpu_wdata = 8'h77;
        tick();
        check("t4_wr_denied", 32'(cpu_denied), 32'h1);
        cpu_req = 1'b0;
        repeat (2) tick();
        check("t4_wr_mem", 32'(ram[13'h0040]), 32'h083);
        ppu_lock = 1'b0;

        // Lock rising during a CPU write does not abort it
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'h3C;
        tick();
        ppu_lock = 1'b1;
        repeat (ACC - 1) tick();
        cpu_req = 1'b0;
        tick();
        check("t5_done", 32'(cpu_done), 32'h1);
        check("t5_not_denied", 32'(cpu_denied), 32'h0);
        check("t5_mem", 32'(ram[13'h0123]), 32'h3C);
        ppu_lock = 1'b0;
        tick();

        // dma and cpu both held high: grant order
        dma_addr = 13'h0222; cpu_addr = 13'h0333; cpu_wr = 1'b0;
        dma_req = 1'b1; cpu_req = 1'b1;
        n_grants = 0;
        for (int c = 0; c < 40 && n_grants < 4; c++) begin
            tick();
            if (dma_done) begin grants[n_grants] = 2; n_grants++; end
            else if (cpu_done) begin grants[n_grants] = 3; n_grants++; end
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        check("t6_grants_seen", 32'(n_grants), 32'd4);
        for (int i = 0; i < n_grants; i++) check("t6_grant_order", 32'(grants[i]), 32'(exp_grants[i]));
        repeat (ACC + 2) tick();

        // Randomized traffic on a small address window
        for (int c = 0; c < 3000; c++) begin
            ppu_req   = ($urandom_range(0, 3) == 0);
            dma_req   = ($urandom_range(0, 2) == 0);
            cpu_req   = ($urandom_range(0, 1) == 0);
            cpu_wr    = 1'($urandom_range(0, 1));
            ppu_addr  = 13'($urandom_range(0, 15));
            dma_addr  = 13'($urandom_range(0, 15));
            cpu_addr  = 13'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ppu_lock = ~ppu_lock;
            tick();
        end
        ppu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
        repeat (ACC + 3) tick();

        diffs = 0;
        for (int i = 0; i < 8192; i++) if (ram[i] !== ref_mem[i]) diffs++;
        check("final_mem_diffs", 32'(diffs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
